cc_miss_req_ctrl: RTL
=====================

Name: cc_miss_req_ctrl

Overview:
Sequences cache-miss line fills in the cache controller. Accepts miss requests from the tag-compare stage and pushes each miss address into the miss-address FIFO that the data fill unit drains. Issues the matching AXI AR burst (8 beats × 64 bit = one 512-bit line) and limits the number of in-flight fills, retiring each one on the R-channel last beat.

Parameters:
MAX_OUTSTANDING, 2, maximum fills in flight (AR accepted or pending, last R beat not yet seen); range 1..7
ARID, 4'd0, constant AXI ID driven on mem_arid_o

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
miss_req_valid_i  input  1  miss request from tag-compare stage
miss_req_addr_i  input  32  miss byte address: tag [31:15], index [14:6], word [5:3]
miss_req_ready_o  output  1  request accepted this cycle when valid & ready
miss_addr_fifo_full_i  input  1  miss-address FIFO full
miss_addr_fifo_wren_o  output  1  FIFO push strobe
miss_addr_fifo_wdata_o  output  32  address pushed (word-aligned, [2:0]=0)
mem_arid_o  output  4  AR ID (=ARID)
mem_araddr_o  output  32  AR address
mem_arlen_o  output  4  AR length, constant 4'd7
mem_arsize_o  output  3  AR size, constant 3'b011 (8 B)
mem_arburst_o  output  2  AR burst type
mem_arvalid_o  output  1  AR valid
mem_arready_i  input  1  AR ready
mem_rvalid_i  input  1  R valid (monitored only)
mem_rready_i  input  1  R ready (monitored only)
mem_rlast_i  input  1  R last (monitored only)
outstanding_o  output  3  fills currently in flight
fill_done_o  output  1  one-cycle pulse, registered, one cycle after each last-beat handshake
err_o  output  1  sticky: last beat seen with outstanding==0

Behaviour:
- Reset (async, rst_n low): state IDLE; outstanding 0; addr register 0; mem_arvalid_o 0; mem_araddr_o 0; miss_addr_fifo_wren_o 0; fill_done_o 0; err_o 0; miss_req_ready_o 0 while rst_n low.
- States: IDLE, ISSUE.
- IDLE:
  - miss_req_ready_o = !miss_addr_fifo_full_i && (outstanding < MAX_OUTSTANDING); purely combinational from registered state, and from fifo_full.
  - On valid & ready: latch {addr[31:3],3'b0}; assert miss_addr_fifo_wren_o combinationally that same cycle with wdata = the same value; outstanding +1 next edge; go to ISSUE.
- ISSUE:
  - miss_req_ready_o = 0; mem_arvalid_o = 1; mem_araddr_o = latched address.
  - araddr and arvalid stay stable until mem_arready_i; then return to IDLE next edge.
  - Best case: one accept every 2 cycles; minimum AR latency is 1 cycle after accept.
- Retire: rvalid & rready & rlast decrements outstanding and pulses fill_done_o next cycle. Allowed in any state.
- Simultaneous accept and retire in one cycle: outstanding unchanged.
- Retire with outstanding==0: counter holds at 0; err_o set until reset.
- outstanding == MAX_OUTSTANDING: ready low. A retire in the same cycle does not reopen ready until the next cycle.
- FIFO full: no accept, no push. A push is never issued while full.
- The FIFO push precedes the AR handshake, so fill-unit ordering matches AR order. The memory returns bursts in order (single ID).
- A request never has its FIFO push without its AR issue: once accepted, ISSUE completes regardless of miss_req_valid_i.

Optional Feature:
CC_CWF_EN
- Defined: critical-word-first. araddr and FIFO wdata keep bits [5:3] of the request; mem_arburst_o = 2'b10 (WRAP).
- Undefined: araddr and FIFO wdata forced line-aligned ({addr[31:6],6'b0}); mem_arburst_o = 2'b01 (INCR). The fill unit sees offset 0.

Decomposition:
- Package cc_miss_pkg: state enum (IDLE, ISSUE); constants CC_ARLEN=4'd7, CC_ARSIZE=3'b011, BURST_INCR=2'b01, BURST_WRAP=2'b10; address-field widths and offsets (tag 17, index 9, word 3).
- One natural sub-module: cc_outstanding_cnt (up/down saturating counter with underflow flag). FSM and AR driver stay in the top.

Test Plan:
- Single miss, addr 0x0001_2348, arready after 3 cycles -> one FIFO push; arvalid held 3 cycles with stable araddr. With CWF_EN: push 0x0001_2348, araddr 0x0001_2348, arburst 2'b10. Without: 0x0001_2340, arburst 2'b01. outstanding goes 1, returns to 0 after an 8-beat R burst with rlast; fill_done_o pulses once.
- Back-to-back valid with MAX_OUTSTANDING=2, arready=1, no R traffic -> two accepts 2 cycles apart; third request stalled with ready=0 until the first rlast handshake. Ready rises the cycle after.
- miss_addr_fifo_full_i=1 with valid held -> no push, no arvalid, ready=0. Full drops -> accept that cycle.
- Accept and rlast handshake in the same cycle with outstanding=1 -> outstanding stays 1; fill_done_o pulses.
- rlast handshake with outstanding=0 -> outstanding stays 0; err_o=1 and stays 1 until reset.
- rst_n asserted mid-ISSUE (arvalid high) -> arvalid, wren, outstanding and err_o go 0 immediately without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/cc_miss_pkg.sv
// Shared types and constants for the cache-miss request controller.
// CC_CWF_EN selects critical-word-first (WRAP) instead of line-aligned INCR fills.
package cc_miss_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } cc_miss_state_e;

  localparam logic [3:0] CC_ARLEN   = 4'd7;
  localparam logic [2:0] CC_ARSIZE  = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  localparam int BYTE_W   = 3;
  localparam int WORD_W   = 3;
  localparam int IDX_W    = 9;
  localparam int TAG_W    = 17;
  localparam int WORD_LSB = BYTE_W;
  localparam int IDX_LSB  = WORD_LSB + WORD_W;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;

`ifdef CC_CWF_EN
  localparam logic [1:0] CC_BURST = BURST_WRAP;
`else
  localparam logic [1:0] CC_BURST = BURST_INCR;
`endif

  function automatic logic [31:0] cc_align(
    input logic [31:0] a
  );
`ifdef CC_CWF_EN
    return {a[31:WORD_LSB], {WORD_LSB{1'b0}}};
`else
    return {a[31:IDX_LSB], {IDX_LSB{1'b0}}};
`endif
  endfunction

endpackage

// File: rtl/cc_miss_req_ctrl_cnt.sv
// In-flight fill counter: saturating up/down with sticky underflow flag.
module cc_outstanding_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [2:0] o_cnt,
  output logic       o_err
);

  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_err;
  logic       w_inc_ok;
  logic       w_dec_ok;
  logic       w_under;

  assign w_inc_ok = i_inc && (r_cnt != 3'd7);
  assign w_dec_ok = i_dec && (r_cnt != 3'd0);
  assign w_under  = i_dec && (r_cnt == 3'd0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_inc_ok, w_dec_ok})
      2'b10:   w_cnt_nxt = r_cnt + 3'd1;
      2'b01:   w_cnt_nxt = r_cnt - 3'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_under) r_err <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

// File: rtl/cc_miss_req_ctrl.sv
// Miss request sequencer: FIFO push, AXI AR line-fill issue, in-flight limit.
// Build option: CC_CWF_EN enables critical-word-first WRAP bursts.
module cc_miss_req_ctrl
  import cc_miss_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  output logic [2:0]  outstanding_o,
  output logic        fill_done_o,
  output logic        err_o
);

  localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);

  cc_miss_state_e r_state;
  cc_miss_state_e w_state_nxt;
  logic [31:0]    r_addr;
  logic [31:0]    w_req_addr;
  logic           r_fill_done;
  logic           w_ready;
  logic           w_accept;
  logic           w_retire;
  logic [2:0]     w_cnt;
  logic           w_err;

  assign w_req_addr = cc_align(miss_req_addr_i);
  assign w_retire   = mem_rvalid_i && mem_rready_i && mem_rlast_i;
  assign w_accept   = miss_req_valid_i && w_ready;

  // rst_n gates ready so nothing is accepted while reset is held
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        w_ready = rst_n && !miss_addr_fifo_full_i && (w_cnt < MAX_C);
        if (miss_req_valid_i && w_ready) w_state_nxt = ST_ISSUE;
      end
      (r_state == ST_ISSUE): begin
        if (mem_arready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'd0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_done <= w_retire;
      if (w_accept) r_addr <= w_req_addr;
    end
  end

  cc_outstanding_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_accept),
    .i_dec (w_retire),
    .o_cnt (w_cnt),
    .o_err (w_err)
  );

  assign miss_req_ready_o       = w_ready;
  assign miss_addr_fifo_wren_o  = w_accept;
  assign miss_addr_fifo_wdata_o = w_req_addr;
  assign mem_arid_o             = ARID;
  assign mem_araddr_o           = r_addr;
  assign mem_arlen_o            = CC_ARLEN;
  assign mem_arsize_o           = CC_ARSIZE;
  assign mem_arburst_o          = CC_BURST;
  assign mem_arvalid_o          = (r_state == ST_ISSUE);
  assign outstanding_o          = w_cnt;
  assign fill_done_o            = r_fill_done;
  assign err_o                  = w_err;

endmodule
